// File: rtl/mario_tile_poll_responder_if.sv
// Signal bundle between Mario's logic, the level tile RAM and the poll responder.
// The responder connects through the slave modport; Mario/RAM side uses master.
interface mario_tile_poll_responder_if;
  logic        frame_clk;
  logic [9:0]  Mario_X_Pos;
  logic [9:0]  Mario_Y_Pos;
  logic        Shift;
  logic [12:0] map_addr;
  logic [2:0]  map_data;
  logic [2:0]  mario_poll_up;
  logic [2:0]  mario_poll_down;
  logic [2:0]  mario_poll_left;
  logic [2:0]  mario_poll_right;
  logic        poll_valid;
  logic        busy;
  logic [7:0]  scroll_col;

  modport slave (
    input  frame_clk, Mario_X_Pos, Mario_Y_Pos, Shift, map_data,
    output map_addr, mario_poll_up, mario_poll_down, mario_poll_left,
           mario_poll_right, poll_valid, busy, scroll_col
  );

  modport master (
    output frame_clk, Mario_X_Pos, Mario_Y_Pos, Shift, map_data,
    input  map_addr, mario_poll_up, mario_poll_down, mario_poll_left,
           mario_poll_right, poll_valid, busy, scroll_col
  );
endinterface

// File: rtl/mario_tile_poll_responder.sv
// Answers Mario's up/down/left/right neighbour-tile polls from the level tile RAM,
// one probe at a time, publishing all four codes together once a poll completes.
module mario_tile_poll_responder #(
  parameter logic [9:0] X_MIN      = 10'd120,
  parameter logic [9:0] X_MAX      = 10'd519,
  parameter logic [9:0] Y_MIN      = 10'd40,
  parameter logic [9:0] Y_MAX      = 10'd439,
  parameter logic [9:0] HALF       = 10'd20,
  parameter logic [9:0] TILE       = 10'd20,
  parameter logic [7:0] SHIFT_COLS = 8'd2,
  parameter logic [2:0] OOB_CODE   = 3'b000
) (
  input logic                          Clk,
  input logic                          Reset,
  mario_tile_poll_responder_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, DIVX, DIVY, READ, WAIT, DONE} state_t;

  state_t      state_reg, state_next;
  logic        frame_clk_reg;
  logic [9:0]  x_snap_reg, y_snap_reg;
  logic [1:0]  probe_reg;
  logic [9:0]  acc_reg;
  logic [4:0]  col_off_reg, row_reg;
  logic [12:0] map_addr_reg;
  logic [7:0]  scroll_col_reg;
  logic        poll_valid_reg, busy_reg;

  logic        frame_edge, probe_oob, last_probe;
  logic [9:0]  px, py, dx, dy, acc_step;
  logic [7:0]  col_sum;
  logic [12:0] read_addr;
  logic        load_snap, x_step, y_step, acc_clr, next_probe, probe_start;
  logic        read_en, commit, shadow_we;
  logic [2:0]  shadow_wdata;

  assign frame_edge = bus.frame_clk & ~frame_clk_reg;
  assign last_probe = (probe_reg == 2'd3);

  // Probe order UP, DOWN, LEFT, RIGHT; underflow wraps high and so lands out of bounds.
  always_comb begin
    px = x_snap_reg;
    py = y_snap_reg;
    case (probe_reg)
      2'd0:    py = y_snap_reg - HALF - 10'd1;
      2'd1:    py = y_snap_reg + HALF;
      2'd2:    px = x_snap_reg - HALF - 10'd1;
      default: px = x_snap_reg + HALF;
    endcase
  end

  assign probe_oob = (px < X_MIN) || (px > X_MAX) || (py < Y_MIN) || (py > Y_MAX);
  assign dx        = px - X_MIN;
  assign dy        = py - Y_MIN;
  assign acc_step  = acc_reg + TILE;
  assign col_sum   = scroll_col_reg + {3'b000, col_off_reg};
  assign read_addr = {row_reg, col_sum};
  assign probe_start = load_snap | next_probe;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    load_snap    = 1'b0;
    x_step       = 1'b0;
    y_step       = 1'b0;
    acc_clr      = 1'b0;
    next_probe   = 1'b0;
    read_en      = 1'b0;
    commit       = 1'b0;
    shadow_we    = 1'b0;
    shadow_wdata = bus.map_data;
    case (state_reg)
      IDLE: if (frame_edge) begin
        load_snap  = 1'b1;
        acc_clr    = 1'b1;
        state_next = DIVX;
      end
      DIVX: begin
        if (probe_oob) begin
          shadow_we    = 1'b1;
          shadow_wdata = OOB_CODE;
          next_probe   = 1'b1;
          acc_clr      = 1'b1;
          state_next   = last_probe ? DONE : DIVX;
        end else if (acc_step <= dx) begin
          x_step = 1'b1;
        end else begin
          acc_clr    = 1'b1;
          state_next = DIVY;
        end
      end
      DIVY: begin
        if (acc_step <= dy) y_step = 1'b1;
        else                state_next = READ;
      end
      READ: begin
        read_en    = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        shadow_we  = 1'b1;
        next_probe = 1'b1;
        acc_clr    = 1'b1;
        state_next = last_probe ? DONE : DIVX;
      end
      DONE: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_clk_reg  <= 1'b0;
      scroll_col_reg <= 8'd0;
      x_snap_reg     <= 10'd0;
      y_snap_reg     <= 10'd0;
      probe_reg      <= 2'd0;
      busy_reg       <= 1'b0;
      acc_reg        <= 10'd0;
      col_off_reg    <= 5'd0;
      row_reg        <= 5'd0;
      map_addr_reg   <= 13'd0;
      poll_valid_reg <= 1'b0;
    end else begin
      frame_clk_reg <= bus.frame_clk;
      if (bus.Shift) scroll_col_reg <= scroll_col_reg + SHIFT_COLS;
      if (load_snap) begin
        x_snap_reg <= bus.Mario_X_Pos;
        y_snap_reg <= bus.Mario_Y_Pos;
        probe_reg  <= 2'd0;
        busy_reg   <= 1'b1;
      end else if (next_probe) begin
        probe_reg <= probe_reg + 2'd1;
      end
      if (acc_clr)               acc_reg <= 10'd0;
      else if (x_step || y_step) acc_reg <= acc_step;
      if (probe_start) begin
        col_off_reg <= 5'd0;
        row_reg     <= 5'd0;
      end else begin
        if (x_step) col_off_reg <= col_off_reg + 5'd1;
        if (y_step) row_reg     <= row_reg + 5'd1;
      end
      if (read_en) map_addr_reg <= read_addr;
      poll_valid_reg <= commit;
      if (commit) busy_reg <= 1'b0;
    end
  end

  // Shadows collect a poll privately; outputs only change together on commit.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_probe
      logic [2:0] shadow_reg, poll_reg;
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          shadow_reg <= 3'd0;
          poll_reg   <= 3'd0;
        end else begin
          if (shadow_we && (probe_reg == gi)) shadow_reg <= shadow_wdata;
          if (commit) poll_reg <= shadow_reg;
        end
      end
    end
  endgenerate

  // Address is presented during READ so the registered RAM returns data in WAIT.
  assign bus.map_addr         = (state_reg == READ) ? read_addr : map_addr_reg;
  assign bus.mario_poll_up    = g_probe[0].poll_reg;
  assign bus.mario_poll_down  = g_probe[1].poll_reg;
  assign bus.mario_poll_left  = g_probe[2].poll_reg;
  assign bus.mario_poll_right = g_probe[3].poll_reg;
  assign bus.poll_valid       = poll_valid_reg;
  assign bus.busy             = busy_reg;
  assign bus.scroll_col       = scroll_col_reg;

endmodule

// File: tb/tb_mario_tile_poll_responder.sv
module tb_mario_tile_poll_responder;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  mario_tile_poll_responder_if bus_if();

  mario_tile_poll_responder dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_if.slave)
  );

  logic [2:0]  mem [8192];
  always @(posedge Clk) bus_if.map_data <= mem[bus_if.map_addr];

  int checks = 0;
  int errors = 0;
  int pv_count = 0;
  logic [12:0] addr_log [$];
  logic [12:0] last_addr = 13'd0;

  always @(negedge Clk) begin
    if (bus_if.poll_valid) pv_count++;
    if (bus_if.map_addr != last_addr) addr_log.push_back(bus_if.map_addr);
    last_addr = bus_if.map_addr;
  end

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] up;
    logic [2:0] down;
    logic [2:0] left;
    logic [2:0] right;
    int         reads;
    int         lat;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic start_edge(input logic [9:0] x, input logic [9:0] y);
    @(posedge Clk); #1;
    bus_if.Mario_X_Pos = x;
    bus_if.Mario_Y_Pos = y;
    bus_if.frame_clk   = 1'b1;
    @(posedge Clk); #1;
    bus_if.frame_clk   = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      if (bus_if.poll_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic run_poll(input logic [9:0] x, input logic [9:0] y, output int lat);
    addr_log.delete();
    pv_count = 0;
    start_edge(x, y);
    check("busy_rise", int'(bus_if.busy), 1);
    wait_valid(lat);
    check("valid_seen", int'(lat >= 0), 1);
    check("busy_at_valid", int'(bus_if.busy), 0);
    @(negedge Clk);
    check("valid_pulse_width", int'(bus_if.poll_valid), 0);
    check("valid_count", pv_count, 1);
    $display("poll x=%0d y=%0d up=%b down=%b left=%b right=%b lat=%0d reads=%0d scroll=%0d",
             x, y, bus_if.mario_poll_up, bus_if.mario_poll_down, bus_if.mario_poll_left,
             bus_if.mario_poll_right, lat, addr_log.size(), bus_if.scroll_col);
  endtask

  task automatic check_codes(input logic [2:0] up, input logic [2:0] down,
                             input logic [2:0] left, input logic [2:0] right);
    check("poll_up",    int'(bus_if.mario_poll_up),    int'(up));
    check("poll_down",  int'(bus_if.mario_poll_down),  int'(down));
    check("poll_left",  int'(bus_if.mario_poll_left),  int'(left));
    check("poll_right", int'(bus_if.mario_poll_right), int'(right));
  endtask

  task automatic shift_cycles(input int n);
    @(posedge Clk); #1;
    bus_if.Shift = 1'b1;
    repeat (n) @(posedge Clk);
    #1;
    bus_if.Shift = 1'b0;
  endtask

  initial begin
    int lat;
    bus_if.frame_clk   = 1'b0;
    bus_if.Mario_X_Pos = 10'd0;
    bus_if.Mario_Y_Pos = 10'd0;
    bus_if.Shift       = 1'b0;
    for (int a = 0; a < 8192; a++) mem[a] = 3'b000;
    mem[4866] = 3'b001;  mem[4098] = 3'b010;  mem[4608] = 3'b011;  mem[4611] = 3'b100;
    mem[258]  = 3'b110;  mem[0]    = 3'b101;  mem[3]    = 3'b111;
    mem[4627] = 3'b011;  mem[4882] = 3'b010;
    mem[512]  = 3'b100;  mem[257]  = 3'b001;

    //          x       y       up      down    left    right   reads lat
    vecs[0] = '{10'd160, 10'd400, 3'b010, 3'b001, 3'b011, 3'b100, 4, 95};
    vecs[1] = '{10'd160, 10'd40,  3'b000, 3'b110, 3'b101, 3'b111, 3, 20};
    vecs[2] = '{10'd10,  10'd200, 3'b000, 3'b000, 3'b000, 3'b000, 0, 5};
    vecs[3] = '{10'd519, 10'd439, 3'b011, 3'b000, 3'b010, 3'b000, 2, 85};
    vecs[4] = '{10'd120, 10'd60,  3'b000, 3'b100, 3'b000, 3'b001, 2, 15};

    // Reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_codes(3'b000, 3'b000, 3'b000, 3'b000);
    check("rst_poll_valid", int'(bus_if.poll_valid), 0);
    check("rst_busy", int'(bus_if.busy), 0);
    check("rst_scroll", int'(bus_if.scroll_col), 0);
    check("rst_map_addr", int'(bus_if.map_addr), 0);
    #2 Reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      run_poll(vecs[v].x, vecs[v].y, lat);
      check_codes(vecs[v].up, vecs[v].down, vecs[v].left, vecs[v].right);
      check("ram_reads", addr_log.size(), vecs[v].reads);
      check("latency", lat, vecs[v].lat);
    end

    // Scroll offset feeds the column address
    repeat (3) begin
      @(posedge Clk); #1 bus_if.Shift = 1'b1;
      @(posedge Clk); #1 bus_if.Shift = 1'b0;
    end
    check("scroll_6", int'(bus_if.scroll_col), 6);
    mem[4872] = 3'b101;
    run_poll(10'd160, 10'd400, lat);
    check_codes(3'b000, 3'b101, 3'b000, 3'b000);
    check("addr_up_s6", (addr_log.size() > 0) ? int'(addr_log[0]) : -1, 4104);
    check("addr_down_s6", (addr_log.size() > 1) ? int'(addr_log[1]) : -1, 4872);

    // Column wraps modulo 256
    shift_cycles(124);
    check("scroll_254", int'(bus_if.scroll_col), 254);
    mem[4864] = 3'b110;
    mem[4609] = 3'b011;
    run_poll(10'd160, 10'd400, lat);
    check_codes(3'b000, 3'b110, 3'b000, 3'b011);
    check("addr_up_wrap", (addr_log.size() > 0) ? int'(addr_log[0]) : -1, 4096);
    check("addr_down_wrap", (addr_log.size() > 1) ? int'(addr_log[1]) : -1, 4864);
    check("addr_left_wrap", (addr_log.size() > 2) ? int'(addr_log[2]) : -1, 4862);
    check("addr_right_wrap", (addr_log.size() > 3) ? int'(addr_log[3]) : -1, 4609);
    shift_cycles(1);
    check("scroll_wrap_0", int'(bus_if.scroll_col), 0);

    // Edge while busy is ignored
    pv_count = 0;
    start_edge(10'd160, 10'd400);
    repeat (29) @(posedge Clk);
    start_edge(10'd519, 10'd439);
    repeat (250) @(negedge Clk);
    check("busy_edge_valid_count", pv_count, 1);
    check_codes(3'b010, 3'b001, 3'b011, 3'b100);
    $display("poll x=160 y=400 with ignored edge valid_count=%0d", pv_count);

    // Reset while dividing the UP probe row
    shift_cycles(1);
    check("scroll_pre_reset", int'(bus_if.scroll_col), 2);
    start_edge(10'd160, 10'd400);
    repeat (8) @(posedge Clk);
    #3 Reset = 1'b1;
    #1;
    check_codes(3'b000, 3'b000, 3'b000, 3'b000);
    check("midrst_busy", int'(bus_if.busy), 0);
    check("midrst_valid", int'(bus_if.poll_valid), 0);
    check("midrst_scroll", int'(bus_if.scroll_col), 0);
    check("midrst_map_addr", int'(bus_if.map_addr), 0);
    $display("reset mid-poll busy=%0d up=%b", bus_if.busy, bus_if.mario_poll_up);
    repeat (2) @(posedge Clk);
    #3 Reset = 1'b0;
    repeat (2) @(posedge Clk);
    run_poll(10'd160, 10'd400, lat);
    check_codes(3'b010, 3'b001, 3'b011, 3'b100);
    check("post_reset_latency", lat, 95);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
